// File: rtl/spell_mem_router.sv
// Registered spell-core memory front end: decodes one request at a time to
// internal memory or the IO window and waits for completion with a bounded timeout.
module spell_mem_router #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int IO_BASE  = 'h20,
  parameter int IO_LIMIT = 'h60,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              select,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              memory_type_data,
  input  logic              write,
  output logic [DATA_W-1:0] data_out,
  output logic              data_ready,
  output logic              bus_error,
  input  logic              err_clear,
  output logic              mem_select,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_type_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              io_select,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_wdata,
  output logic              io_write,
  input  logic [DATA_W-1:0] io_rdata,
  input  logic              io_ready
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  // One extra bit so an IO_LIMIT of 2^ADDR_W is representable.
  localparam logic [ADDR_W:0] BASE_X = (ADDR_W + 1)'(IO_BASE);
  localparam logic [ADDR_W:0] LIM_X  = (ADDR_W + 1)'(IO_LIMIT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, RELEASE} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_write, lat_type, lat_io;
  logic [CNT_W-1:0]  cnt;
  logic              is_io, tgt_ready, timeout_hit;
  logic [DATA_W-1:0] tgt_rdata;

  assign is_io = memory_type_data && ({1'b0, addr} >= BASE_X) && ({1'b0, addr} < LIM_X);
  assign tgt_ready = lat_io ? io_ready : mem_ready;
  assign tgt_rdata = lat_io ? io_rdata : mem_rdata;
  // Ready in the last wait cycle beats the timeout.
  assign timeout_hit = (state == WAIT) && !tgt_ready && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    data_ready = 1'b0;
    mem_select = 1'b0;
    io_select  = 1'b0;
    case (state)
      IDLE:    if (select) state_d = WAIT;
      WAIT: begin
        mem_select = !lat_io;
        io_select  = lat_io;
        if (tgt_ready || timeout_hit) state_d = RESP;
      end
      RESP: begin
        data_ready = 1'b1;
        state_d    = select ? RELEASE : IDLE;
      end
      RELEASE: if (!select) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
      lat_type  <= 1'b0;
      lat_io    <= 1'b0;
      cnt       <= '0;
      data_out  <= '0;
    end else begin
      case (state)
        IDLE: if (select) begin
          lat_addr  <= addr;
          lat_wdata <= data_in;
          lat_write <= write;
          lat_type  <= memory_type_data;
          lat_io    <= is_io;
          cnt       <= '0;
        end
        WAIT: begin
          if (tgt_ready) begin
            if (!lat_write) data_out <= tgt_rdata;
          end else if (timeout_hit) begin
            if (!lat_write) data_out <= '1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              bus_error <= 1'b0;
    else if (timeout_hit) bus_error <= 1'b1;
    else if (err_clear)   bus_error <= 1'b0;
  end

  assign mem_addr      = lat_addr;
  assign mem_wdata     = lat_wdata;
  assign mem_type_data = lat_type;
  assign mem_write     = lat_write;
  assign io_addr       = lat_addr;
  assign io_wdata      = lat_wdata;
  assign io_write      = lat_write;

endmodule

// File: tb/tb_spell_mem_router.sv
// Bench for spell_mem_router: directed and random requests against a
// transaction-level model of routing, latency, timeout and error flag.
module tb_spell_mem_router;
  localparam int AW = 8, DW = 8, BASE = 'h20, LIM = 'h60, TO = 16;

  logic          clk = 1'b0, rst = 1'b1;
  logic          select = 1'b0, memory_type_data = 1'b0, write = 1'b0, err_clear = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0, mem_rdata = '0, io_rdata = '0;
  logic          mem_ready = 1'b0, io_ready = 1'b0;
  logic [DW-1:0] data_out, mem_wdata, io_wdata;
  logic [AW-1:0] mem_addr, io_addr;
  logic          data_ready, bus_error, mem_select, mem_type_data, mem_write, io_select, io_write;

  spell_mem_router #(.ADDR_W(AW), .DATA_W(DW), .IO_BASE(BASE), .IO_LIMIT(LIM), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .select(select), .addr(addr), .data_in(data_in),
    .memory_type_data(memory_type_data), .write(write), .data_out(data_out),
    .data_ready(data_ready), .bus_error(bus_error), .err_clear(err_clear),
    .mem_select(mem_select), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_type_data(mem_type_data), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .io_select(io_select), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_write(io_write), .io_rdata(io_rdata), .io_ready(io_ready)
  );

  always #5 clk = ~clk;

  int            checks = 0, errors = 0;
  logic [DW-1:0] exp_dout = '0;
  logic          exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit model_is_io(input logic typ, input int a);
    return typ && a >= BASE && a < LIM;
  endfunction

  // delay = WAIT cycles before the target answers; >= TO means never.
  task automatic txn(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic typ,
                     input logic wr, input int delay, input logic [DW-1:0] rd,
                     input int hold, input logic clr);
    bit io, to, done, other_seen, lat_ok, reissue;
    int sel_n, lat, exp_sel;
    io = model_is_io(typ, int'(a));
    to = delay >= TO;
    exp_sel = to ? TO : delay + 1;
    @(negedge clk);
    select = 1'b1; addr = a; data_in = wd; memory_type_data = typ; write = wr; err_clear = clr;
    done = 0; sel_n = 0; lat = 0; other_seen = 0; lat_ok = 1;
    while (!done && lat < TO + 8) begin
      @(negedge clk);
      lat++;
      // Request lines wander after acceptance; the latched copy must not.
      addr = 8'($urandom); data_in = 8'($urandom);
      write = 1'($urandom); memory_type_data = 1'($urandom);
      mem_ready = 1'b0; io_ready = 1'b0;
      mem_rdata = 8'($urandom); io_rdata = 8'($urandom);
      if (data_ready) begin
        done = 1; err_clear = 1'b0;
      end else begin
        if (io ? mem_select : io_select) other_seen = 1;
        if (io ? io_select : mem_select) begin
          if (io) lat_ok &= (io_addr === a) && (io_wdata === wd) && (io_write === wr);
          else    lat_ok &= (mem_addr === a) && (mem_wdata === wd) && (mem_write === wr)
                            && (mem_type_data === typ);
          if (sel_n == delay) begin
            if (io) begin io_ready = 1'b1; io_rdata = rd; end
            else begin mem_ready = 1'b1; mem_rdata = rd; end
          end
          if (io) mem_ready = 1'($urandom);
          else    io_ready = 1'($urandom);
          sel_n++;
        end
      end
    end
    mem_ready = 1'b0; io_ready = 1'b0;
    if (!wr) exp_dout = to ? '1 : rd;
    if (to) exp_err = 1'b1;
    else if (clr) exp_err = 1'b0;
    chk("done", 32'(done), 1);
    chk("sel_cycles", sel_n, exp_sel);
    chk("other_sel", 32'(other_seen), 0);
    chk("latched", 32'(lat_ok), 1);
    chk("latency", lat, exp_sel + 1);
    chk("data_out", 32'(data_out), 32'(exp_dout));
    chk("bus_error", 32'(bus_error), 32'(exp_err));
    chk("resp_sel", 32'(mem_select | io_select), 0);
    reissue = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (mem_select || io_select || data_ready) reissue = 1;
    end
    select = 1'b0;
    @(negedge clk);
    if (mem_select || io_select || data_ready) reissue = 1;
    chk("no_reissue", 32'(reissue), 0);
  endtask

  initial begin
    int r, dl, pick;
    logic [AW-1:0] ra;
    // Reset state
    @(negedge clk);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_ready", 32'(data_ready), 0);
    chk("rst_err", 32'(bus_error), 0);
    chk("rst_sel", 32'(mem_select | io_select), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    rst = 1'b0;

    txn(8'h10, 8'h00, 1, 0, 0, 8'hA5, 0, 0);      // minimum-latency memory read
    txn(8'h20, 8'h3C, 1, 1, 0, 8'h00, 0, 0);      // IO window, first address
    txn(8'h5F, 8'h3C, 1, 1, 1, 8'h00, 0, 0);      // IO window, last address
    txn(8'h60, 8'h3C, 1, 1, 0, 8'h00, 0, 0);      // just past window -> memory
    txn(8'h20, 8'h3C, 0, 1, 2, 8'h00, 0, 0);      // code space -> memory
    txn(8'h40, 8'h00, 1, 0, 100, 8'h00, 0, 0);    // IO timeout
    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0; exp_err = 1'b0;
    chk("err_clear", 32'(bus_error), 0);
    txn(8'h40, 8'h00, 1, 0, TO - 1, 8'h5A, 0, 0); // ready in the final wait cycle
    txn(8'h11, 8'h00, 1, 0, 2, 8'h77, 5, 0);      // select held after completion
    txn(8'h11, 8'h00, 1, 0, 0, 8'h78, 0, 0);
    txn(8'h12, 8'h00, 1, 0, TO + 2, 8'h00, 0, 1); // timeout beats a held clear
    txn(8'h12, 8'h99, 1, 1, 1, 8'h00, 0, 1);      // clear during a good write

    // Reset mid-WAIT
    @(negedge clk);
    select = 1'b1; addr = 8'h30; memory_type_data = 1'b1; write = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_io_sel", 32'(io_select), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_sel", 32'(mem_select | io_select), 0);
    chk("mid_rst_data_out", 32'(data_out), 0);
    chk("mid_rst_ready", 32'(data_ready), 0);
    chk("mid_rst_io_addr", 32'(io_addr), 0);
    @(negedge clk);
    rst = 1'b0; select = 1'b0; exp_dout = '0; exp_err = 1'b0;
    txn(8'h30, 8'h00, 1, 0, 3, 8'hC3, 0, 0);

    // Random traffic, biased to the window edges and the timeout boundary
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(5, 0);
      case (pick)
        0: ra = 8'(BASE - 1);
        1: ra = 8'(BASE);
        2: ra = 8'(LIM - 1);
        3: ra = 8'(LIM);
        default: ra = 8'($urandom);
      endcase
      r = $urandom_range(9, 0);
      dl = (r < 6) ? $urandom_range(4, 0) : (r < 8) ? $urandom_range(TO - 1, TO - 2)
                                                    : TO + $urandom_range(3, 0);
      txn(ra, 8'($urandom), 1'($urandom), 1'($urandom), dl, 8'($urandom),
          $urandom_range(3, 0), 1'($urandom_range(4, 0) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
